// File: rtl/stream_fork_pkg.sv
// Shared types for the stream fork/join family.
// The mode encoding is the same as the join's, so one mode signal can drive both blocks.
package stream_fork_pkg;

  typedef enum logic {
    ALL = 1'b0,
    ANY = 1'b1
  } stream_fork_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fork_state_e;

endpackage

// File: rtl/stream_fork_mode.sv
// Forks one valid/ready stream to NumOut outputs, completing on ALL or ANY selected acceptance.
// Optional transaction counter on cnt_o when STREAM_FORK_MODE_CNT_EN is defined.
module stream_fork_mode
  import stream_fork_pkg::*;
#(
  parameter int NumOut    = 2,
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic [NumOut-1:0]    sel_i,
  input  logic                 mode_i,
  output logic [NumOut-1:0]    valid_o,
  input  logic [NumOut-1:0]    ready_i,
  output logic [DataWidth-1:0] data_o
`ifdef STREAM_FORK_MODE_CNT_EN
  ,
  output logic [CntWidth-1:0]  cnt_o
`endif
);

  if (NumOut < 1 || CntWidth < 1) begin : g_bad_param
    $error("stream_fork_mode: NumOut and CntWidth must be >= 1");
  end

  fork_state_e       state_q, state_d;
  logic [NumOut-1:0] sel_q, sel_d;
  stream_fork_mode_e mode_q, mode_d;
  logic [NumOut-1:0] done_q, done_d;

  logic [NumOut-1:0] eff_sel;
  stream_fork_mode_e eff_mode;
  logic [NumOut-1:0] hs;
  logic              all_done;
  logic              any_done;

  assign data_o = data_i;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    done_d   = done_q;
    eff_sel  = sel_q;
    eff_mode = mode_q;
    valid_o  = '0;
    hs       = '0;
    all_done = 1'b0;
    any_done = 1'b0;
    ready_o  = 1'b0;

    if (state_q == IDLE) begin
      eff_sel  = sel_i;
      eff_mode = stream_fork_mode_e'(mode_i);
    end

    if (!rst_i) begin
      valid_o  = {NumOut{valid_i}} & eff_sel & ~done_q;
      hs       = valid_o & ready_i;
      all_done = (((done_q | hs) & eff_sel) == eff_sel);
      // An empty selection has nobody to wait for, so it completes in ANY mode too.
      any_done = (|hs) || (eff_sel == '0);
      ready_o  = valid_i & ((eff_mode == ALL) ? all_done : any_done);
    end

    case (state_q)
      IDLE: begin
        if (valid_i && !ready_o) begin
          state_d = BUSY;
          sel_d   = sel_i;
          mode_d  = stream_fork_mode_e'(mode_i);
          done_d  = (eff_mode == ALL) ? (hs & sel_i) : '0;
        end
      end
      BUSY: begin
        if (ready_o) begin
          state_d = IDLE;
          done_d  = '0;
        end else if (mode_q == ALL) begin
          done_d = done_q | hs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mode_q  <= ALL;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

`ifdef STREAM_FORK_MODE_CNT_EN
  logic [CntWidth-1:0] cnt_q;

  // Counts dropped (empty-selection) beats as well; wraps silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (valid_i && ready_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_stream_fork_mode.sv
// Directed self-checking bench for stream_fork_mode (NumOut=2, CntWidth=4).
// Counter checks are active when STREAM_FORK_MODE_CNT_EN is defined.
module tb_stream_fork_mode;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready_o;
  logic [7:0]  data;
  logic [1:0]  sel;
  logic        mode;
  logic [1:0]  valid_o;
  logic [1:0]  ready_i;
  logic [7:0]  data_o;
`ifdef STREAM_FORK_MODE_CNT_EN
  logic [3:0]  cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  stream_fork_mode #(
    .NumOut   (2),
    .DataWidth(8),
    .CntWidth (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(valid),
    .ready_o(ready_o),
    .data_i (data),
    .sel_i  (sel),
    .mode_i (mode),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o)
`ifdef STREAM_FORK_MODE_CNT_EN
    ,
    .cnt_o  (cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef STREAM_FORK_MODE_CNT_EN
    chk(tag, 32'(cnt), 32'(exp_cnt % 16));
`endif
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; data = 8'h00; sel = 2'b11; mode = 1'b0; ready_i = 2'b11;
    step(); settle();
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    step();
    rst = 1'b0; valid = 1'b0;
    settle();
    chk_cnt("rst_cnt");

    // ALL: output 0 takes the beat first, output 1 a cycle later
    step();
    valid = 1'b1; sel = 2'b11; mode = 1'b0; ready_i = 2'b01; data = 8'hA5;
    settle();
    chk("all_c0_valid", 32'(valid_o), 32'h3);
    chk("all_c0_ready", 32'(ready_o), 32'd0);
    chk("all_c0_data", 32'(data_o), 32'hA5);
    step();
    ready_i = 2'b10;
    settle();
    chk("all_c1_valid", 32'(valid_o), 32'h2);
    chk("all_c1_ready", 32'(ready_o), 32'd1);
    step(); exp_cnt++;
    // IDLE again: new sel_i is used directly and completes zero-wait
    sel = 2'b01; ready_i = 2'b01; data = 8'h3C;
    settle();
    chk("idle_valid", 32'(valid_o), 32'h1);
    chk("idle_ready", 32'(ready_o), 32'd1);
    chk_cnt("cnt_after_all");
    step(); exp_cnt++;

    // ANY: nobody ready for two cycles, then output 1
    sel = 2'b11; mode = 1'b1; ready_i = 2'b00;
    settle();
    chk("any_c0_valid", 32'(valid_o), 32'h3);
    chk("any_c0_ready", 32'(ready_o), 32'd0);
    step();
    mode = 1'b0; sel = 2'b00;
    settle();
    chk("any_c1_ready", 32'(ready_o), 32'd0);
    chk("any_c1_valid", 32'(valid_o), 32'h3);
    step();
    ready_i = 2'b10;
    settle();
    chk("any_c2_ready", 32'(ready_o), 32'd1);
    step(); exp_cnt++;
    // Cycle 3 doubles as an empty-selection beat: both valids gone, dropped at once
    ready_i = 2'b00;
    settle();
    chk("any_c3_valid", 32'(valid_o), 32'h0);
    chk("empty_ready", 32'(ready_o), 32'd1);
    step(); exp_cnt++;
    valid = 1'b0;
    settle();
    chk_cnt("cnt_after_empty");

    // sel_i change while BUSY is ignored
    step();
    valid = 1'b1; sel = 2'b11; mode = 1'b0; ready_i = 2'b01;
    settle();
    chk("lat_c0_ready", 32'(ready_o), 32'd0);
    step();
    sel = 2'b01; ready_i = 2'b00;
    settle();
    chk("lat_c1_valid", 32'(valid_o), 32'h2);
    chk("lat_c1_ready", 32'(ready_o), 32'd0);
    step();
    ready_i = 2'b01;
    settle();
    chk("lat_c2_ready", 32'(ready_o), 32'd0);
    step();
    ready_i = 2'b10;
    settle();
    chk("lat_c3_ready", 32'(ready_o), 32'd1);
    step(); exp_cnt++;
    valid = 1'b0;

    // Reset while BUSY with output 0 already served
    step();
    valid = 1'b1; sel = 2'b11; mode = 1'b0; ready_i = 2'b01;
    step();
    ready_i = 2'b00;
    settle();
    chk("busy_done_valid", 32'(valid_o), 32'h2);
    rst = 1'b1;
    settle();
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    step(); exp_cnt = 0;
    rst = 1'b0;
    settle();
    chk("represent_valid", 32'(valid_o), 32'h3);
    chk("represent_ready", 32'(ready_o), 32'd0);
    chk_cnt("cnt_after_rst");
    step();
    ready_i = 2'b11;
    settle();
    chk("represent_done", 32'(ready_o), 32'd1);
    step(); exp_cnt++;

    // ANY with both outputs ready together: one consumption
    mode = 1'b1; sel = 2'b11; ready_i = 2'b11;
    settle();
    chk("any_both_valid", 32'(valid_o), 32'h3);
    chk("any_both_ready", 32'(ready_o), 32'd1);
    step(); exp_cnt++;
    chk_cnt("cnt_any_both");

    // 17 back-to-back ALL beats from a fresh reset
    rst = 1'b1;
    step(); exp_cnt = 0;
    rst = 1'b0; mode = 1'b0; sel = 2'b11; ready_i = 2'b11;
    for (int i = 0; i < 17; i++) begin
      data = 8'(i);
      settle();
      chk("b2b_ready", 32'(ready_o), 32'd1);
      step(); exp_cnt++;
      chk_cnt("b2b_cnt");
    end
    valid = 1'b0;
    settle();
    chk("final_valid", 32'(valid_o), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
